dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter KSEG_MAP, default 1, meaning kseg0/kseg1 virtual-to-physical address mapping is enabled (0 = addresses pass through unchanged).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU memory access request (memread | memwrite).
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-007 SHALL have port req_signed  input  1  load result is sign-extended when 1, zero-extended when 0.
REQ-008 SHALL have port req_addr  input  32  virtual byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port stall  output  1  CPU must hold its PC and request while this is high.
REQ-011 SHALL have port resp_valid  output  1  resp_rdata is valid this cycle.
REQ-012 SHALL have port resp_rdata  output  32  extended load result.
REQ-013 SHALL have port addr_err  output  1  misaligned access flag.
REQ-014 SHALL have ports data_sram_en (output, 1), data_sram_wen (output, 4), data_sram_addr (output, 32), data_sram_wdata (output, 32) and data_sram_rdata (input, 32); read data is returned one cycle after en with wen = 0.

Function
REQ-015 SHALL implement an FSM with states IDLE and RD_WAIT.
REQ-016 IDLE, valid store: en = 1 and wen = strobe in the same cycle; stall = 0; next state IDLE.
REQ-017 IDLE, valid load: en = 1, wen = 0, stall = 1; SHALL latch addr[1:0], size and signed; next state RD_WAIT.
REQ-018 RD_WAIT: en = 0, stall = 0, resp_valid = 1; resp_rdata SHALL be extracted from data_sram_rdata using the latched fields; next state IDLE.
REQ-019 RD_WAIT SHALL ignore req_valid (the held request is not reissued); load latency is therefore 2 cycles and store latency 1 cycle.
REQ-020 Strobe: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
REQ-021 Store data: byte replicated 4x, half replicated 2x, word unchanged.
REQ-022 Load extraction: select the byte or half addressed by the latched addr[1:0], then extend to 32 bits per the latched signed bit.
REQ-023 With KSEG_MAP = 1, addr[31:29] of 3'b100 or 3'b101 SHALL map to {3'b000, addr[28:0]}; all other addresses pass through unchanged.
REQ-024 data_sram_addr SHALL have bits [1:0] forced to 0.
REQ-025 With req_valid = 0 in IDLE: en = 0, wen = 0, stall = 0, resp_valid = 0.

Reset
REQ-026 Asserting resetn low SHALL force the FSM to IDLE asynchronously, including when a load is in RD_WAIT; that load's response is dropped.
REQ-027 During reset, all outputs SHALL be 0 and resp_rdata SHALL be 32'h0.

Configuration
REQ-028 With DMEM_ADDR_ERR_EN defined, half accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 SHALL assert addr_err combinationally in IDLE, suppress en and wen, set stall = 0, and leave the FSM in IDLE.
REQ-029 Without DMEM_ADDR_ERR_EN, addr_err SHALL be tied to 0 and misaligned accesses SHALL proceed aligned down.

Structure
REQ-030 Package dmem_pkg SHALL hold the size enum (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the KSEG mask constants.
REQ-031 A combinational sub-module dmem_load_align SHALL perform byte/half selection and extension.

Verification
REQ-032 Store byte to addr 0x8000_0003, wdata 0x0000_00AB -> sram addr 0x0000_0000, wen 4'b1000, wdata 0xABAB_ABAB, stall 0.
REQ-033 Signed half load from 0xA000_0102, sram returns 0x8001_1234 -> stall 1 then 0; resp_rdata 0xFFFF_8001 in cycle 2.
REQ-034 Unsigned byte load from 0x0000_0011, rdata 0x0000_F000 -> resp_rdata 0x0000_00F0.
REQ-035 Word load with resetn pulsed low during RD_WAIT -> state IDLE, resp_valid 0, stall 0, no second en.
REQ-036 Word store to 0x8000_0006 with DMEM_ADDR_ERR_EN defined -> addr_err 1, en 0; without the macro -> wen 4'b1111 at 0x0000_0004.
REQ-037 Back-to-back load then store -> en high in cycles 0 and 2, and no en in cycle 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, FSM states and kseg mapping constants for the dmem bridge
package dmem_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;
    localparam logic [2:0]  KSEG0_SEG = 3'b100;
    localparam logic [2:0]  KSEG1_SEG = 3'b101;
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;
    // kseg0/kseg1 fold onto the low 512 MB; everything else is left untouched
    function automatic logic [31:0] map_addr(input logic [31:0] a, input bit en);
        return (en && (a[31:29] == KSEG0_SEG || a[31:29] == KSEG1_SEG)) ? (a & KSEG_MASK) : a;
    endfunction
endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: CPU-side request/response bus of the data memory bridge
interface dmem_bridge_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_err;
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  stall, resp_valid, resp_rdata, addr_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output stall, resp_valid, resp_rdata, addr_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half out of a read word and extends it
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    // select the lane by offset, then sign- or zero-extend by access size
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        data    = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                  size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU load/store to synchronous SRAM bridge (optional DMEM_ADDR_ERR_EN misalign trap)
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int KSEG_MAP = 1
) (
    input  logic         clk,
    input  logic         resetn,
    dmem_bridge_if.slave cpu,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic [31:0]  data_sram_rdata
);
    state_e      state;
    logic [1:0]  lat_off;
    size_e       lat_size;
    logic        lat_sgn;
    size_e       sz;
    logic        err;
    logic        go;
    logic [3:0]  strobe;
    logic [31:0] wrep;
    logic [31:0] aligned;

    dmem_load_align u_align (
        .rdata (data_sram_rdata),
        .off   (lat_off),
        .size  (lat_size),
        .sgn   (lat_sgn),
        .data  (aligned)
    );

    // request decode and SRAM drive; every output is held at 0 while resetn is low
    always_comb begin
        sz = cpu.req_size == 2'd3 ? SZ_WORD : size_e'(cpu.req_size);
`ifdef DMEM_ADDR_ERR_EN
        err = resetn && state == IDLE && cpu.req_valid &&
              ((sz == SZ_HALF && cpu.req_addr[0]) || (sz == SZ_WORD && cpu.req_addr[1:0] != 2'b00));
`else
        err = 1'b0;
`endif
        go     = resetn && state == IDLE && cpu.req_valid && !err;
        strobe = sz == SZ_BYTE ? 4'b0001 << cpu.req_addr[1:0] :
                 sz == SZ_HALF ? (cpu.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep   = sz == SZ_BYTE ? {4{cpu.req_wdata[7:0]}} :
                 sz == SZ_HALF ? {2{cpu.req_wdata[15:0]}} : cpu.req_wdata;
        data_sram_en    = go;
        data_sram_wen   = (go && cpu.req_write) ? strobe : 4'b0000;
        data_sram_addr  = resetn ? (map_addr(cpu.req_addr, KSEG_MAP != 0) & 32'hFFFF_FFFC) : 32'h0;
        data_sram_wdata = resetn ? wrep : 32'h0;
        cpu.stall       = go && !cpu.req_write;
        cpu.resp_valid  = resetn && state == RD_WAIT;
        cpu.resp_rdata  = cpu.resp_valid ? aligned : 32'h0;
        cpu.addr_err    = err;
    end

    // loads park in RD_WAIT for the SRAM latency; the held request is ignored there
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lat_off  <= 2'b00;
            lat_size <= SZ_BYTE;
            lat_sgn  <= 1'b0;
        end else if (state == IDLE && go && !cpu.req_write) begin
            state    <= RD_WAIT;
            lat_off  <= cpu.req_addr[1:0];
            lat_size <= sz;
            lat_sgn  <= cpu.req_signed;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard bench for dmem_bridge with a behavioural SRAM
module tb_dmem_bridge;
    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_ER = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'h0;
    logic [31:0] mem [logic [31:0]];
    exp_t        sb [$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;

    dmem_bridge_if bus ();

    dmem_bridge #(.KSEG_MAP(1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cpu             (bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: byte-masked writes, reads return one cycle after en
    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'd0) begin
                data_sram_rdata <= mem.exists(data_sram_addr) ? mem[data_sram_addr] : 32'hDEAD_BEEF;
            end else begin
                logic [31:0] w;
                w = mem.exists(data_sram_addr) ? mem[data_sram_addr] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (data_sram_wen[i]) w[i*8 +: 8] = data_sram_wdata[i*8 +: 8];
                mem[data_sram_addr] = w;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with empty scoreboard at %0t", name, $time);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a store, response or error
    always @(negedge clk) begin
        if (data_sram_en && data_sram_wen != 4'd0) begin
            if (sb.size() == 0) unexpected("sb_store");
            else begin
                e = sb.pop_front();
                chk("st_kind", 32'(K_ST), 32'(e.kind));
                chk("st_addr", data_sram_addr, e.addr);
                chk("st_wen", 32'(data_sram_wen), 32'(e.wen));
                chk("st_wdata", data_sram_wdata, e.data);
            end
        end
        if (bus.resp_valid) begin
            if (sb.size() == 0) unexpected("sb_load");
            else begin
                e = sb.pop_front();
                chk("ld_kind", 32'(K_LD), 32'(e.kind));
                chk("ld_rdata", bus.resp_rdata, e.data);
            end
        end
        if (bus.addr_err) begin
            if (sb.size() == 0) unexpected("sb_err");
            else begin
                e = sb.pop_front();
                chk("err_kind", 32'(K_ER), 32'(e.kind));
                chk("err_en", 32'(data_sram_en), 32'h0);
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic [31:0] ea, input logic [3:0] ew, input logic [31:0] ed);
        cyc();
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        sb.push_back('{K_ST, ea, ew, ed});
        @(negedge clk);
        chk("st_stall", 32'(bus.stall), 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ea, input logic [31:0] ed);
        cyc();
        drive(1'b1, 1'b0, sz, sg, a, 32'h0);
        sb.push_back('{K_LD, 32'h0, 4'h0, ed});
        @(negedge clk);
        chk("ld_stall0", 32'(bus.stall), 32'h1);
        chk("ld_en0", 32'(data_sram_en), 32'h1);
        chk("ld_wen0", 32'(data_sram_wen), 32'h0);
        chk("ld_addr", data_sram_addr, ea);
        cyc();
        @(negedge clk);
        chk("ld_stall1", 32'(bus.stall), 32'h0);
        chk("ld_en1", 32'(data_sram_en), 32'h0);
        chk("ld_valid1", 32'(bus.resp_valid), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        mem[32'h0000_0100] = 32'h8001_1234;
        mem[32'h0000_0010] = 32'h0000_F000;
        mem[32'h0000_0020] = 32'h8012_3456;
        resetn = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hFFFF_FFFF);
        #3;
        chk("rst_en", 32'(data_sram_en), 32'h0);
        chk("rst_wen", 32'(data_sram_wen), 32'h0);
        chk("rst_addr", data_sram_addr, 32'h0);
        chk("rst_wdata", data_sram_wdata, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus.addr_err), 32'h0);
        cyc();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("idle_en", 32'(data_sram_en), 32'h0);
        chk("idle_wen", 32'(data_sram_wen), 32'h0);
        chk("idle_stall", 32'(bus.stall), 32'h0);
        chk("idle_valid", 32'(bus.resp_valid), 32'h0);

        store(32'h8000_0003, 32'h0000_00AB, 2'd0, 32'h0000_0000, 4'b1000, 32'hABAB_ABAB);
        load(32'hA000_0102, 2'd1, 1'b1, 32'h0000_0100, 32'hFFFF_8001);
        load(32'h0000_0011, 2'd0, 1'b0, 32'h0000_0010, 32'h0000_00F0);
        load(32'h0000_0023, 2'd0, 1'b1, 32'h0000_0020, 32'hFFFF_FF80);
        load(32'h0000_0020, 2'd1, 1'b0, 32'h0000_0020, 32'h0000_3456);
        load(32'h8000_0020, 2'd2, 1'b1, 32'h0000_0020, 32'h8012_3456);
        store(32'h0000_0042, 32'h1234_BEEF, 2'd1, 32'h0000_0040, 4'b1100, 32'hBEEF_BEEF);
        store(32'hC000_0010, 32'h0102_0304, 2'd2, 32'hC000_0010, 4'b1111, 32'h0102_0304);
        store(32'h2000_0004, 32'h5566_7788, 2'd3, 32'h2000_0004, 4'b1111, 32'h5566_7788);

        // reset pulse while a word load sits in RD_WAIT
        cyc();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        chk("rw_stall0", 32'(bus.stall), 32'h1);
        cyc();
        #1 resetn = 1'b0;
        #1;
        chk("rw_valid", 32'(bus.resp_valid), 32'h0);
        chk("rw_stall", 32'(bus.stall), 32'h0);
        chk("rw_en", 32'(data_sram_en), 32'h0);
        chk("rw_rdata", bus.resp_rdata, 32'h0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rw_post_valid", 32'(bus.resp_valid), 32'h0);
        chk("rw_post_en", 32'(data_sram_en), 32'h0);
        cyc();
        @(negedge clk);
        chk("rw_post2_en", 32'(data_sram_en), 32'h0);
        chk("rw_post2_valid", 32'(bus.resp_valid), 32'h0);

`ifdef DMEM_ADDR_ERR_EN
        cyc();
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0006, 32'h1122_3344);
        sb.push_back('{K_ER, 32'h0, 4'h0, 32'h0});
        @(negedge clk);
        chk("mis_err", 32'(bus.addr_err), 32'h1);
        chk("mis_en", 32'(data_sram_en), 32'h0);
        chk("mis_wen", 32'(data_sram_wen), 32'h0);
        chk("mis_stall", 32'(bus.stall), 32'h0);
        cyc();
        drive(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0021, 32'h0);
        sb.push_back('{K_ER, 32'h0, 4'h0, 32'h0});
        @(negedge clk);
        chk("mis_ld_stall", 32'(bus.stall), 32'h0);
        cyc();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis_ld_idle", 32'(bus.resp_valid), 32'h0);
`else
        store(32'h8000_0006, 32'h1122_3344, 2'd2, 32'h0000_0004, 4'b1111, 32'h1122_3344);
        chk("mis_err", 32'(bus.addr_err), 32'h0);
        load(32'h0000_0021, 2'd1, 1'b1, 32'h0000_0020, 32'h0000_3456);
`endif

        // back-to-back load then store: en in cycles 0 and 2 only
        load(32'h0000_0010, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_F000);
        store(32'h0000_0030, 32'h0000_005A, 2'd0, 32'h0000_0030, 4'b0001, 32'h5A5A_5A5A);
        chk("b2b_en2", 32'(data_sram_en), 32'h1);

        cyc();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
